// File: rtl/umi_endpoint_pipe_if.sv
// Signal bundle for umi_endpoint_pipe: UMI device request/response channels and
// the local memory/register port. The endpoint uses the slave view.
interface umi_endpoint_pipe_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
);
    logic          udev_req_valid;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready;
    logic [AW-1:0] loc_addr;
    logic          loc_write;
    logic          loc_read;
    logic          loc_atomic;
    logic [7:0]    loc_opcode;
    logic [2:0]    loc_size;
    logic [7:0]    loc_len;
    logic [7:0]    loc_atype;
    logic [DW-1:0] loc_wrdata;
    logic [DW-1:0] loc_rddata;
    logic          loc_ready;
    logic          err_drop;

    modport slave (
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        input  udev_resp_ready, loc_rddata, loc_ready,
        output udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
        output udev_resp_srcaddr, udev_resp_data,
        output loc_addr, loc_write, loc_read, loc_atomic, loc_opcode, loc_size, loc_len,
        output loc_atype, loc_wrdata, err_drop
    );

    modport master (
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        output udev_resp_ready, loc_rddata, loc_ready,
        input  udev_req_ready, udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr,
        input  udev_resp_srcaddr, udev_resp_data,
        input  loc_addr, loc_write, loc_read, loc_atomic, loc_opcode, loc_size, loc_len,
        input  loc_atype, loc_wrdata, err_drop
    );
endinterface

// File: rtl/umi_endpoint_pipe.sv
// UMI device endpoint: fixed-latency local access pipeline feeding a credit-guarded
// response queue; illegal requests become error responses or dropped pulses.
module umi_endpoint_pipe #(
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 256,
    parameter int RDLAT  = 1,
    parameter int DEPTH  = 4,
    parameter int ERRCHK = 1
) (
    input  logic               clk,
    input  logic               reset,
    umi_endpoint_pipe_if.slave bus
);
    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_REQ_ATOMIC = 5'h09;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CRW = $clog2(DEPTH + 1);
    localparam logic [CRW-1:0] DEPTH_C  = CRW'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
    localparam logic [16:0]    MAX_BYTES = 17'(DW / 8);

    logic [4:0]    opc_s;
    logic [2:0]    size_s;
    logic [7:0]    len_s;
    logic [16:0]   bytes_s;
    logic          is_read_s, is_write_s, is_posted_s, is_atomic_s, is_rg_s, is_unsup_s;
    logic          illegal_s, ready_s, accept_s, push_s, pop_s;
    logic [CW-1:0] resp_cmd_s;
    logic [DW-1:0] push_data_s;

    logic          rdy_en_q, err_drop_q;
    logic [CRW-1:0] credit_q, credit_d, count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic          pv_q   [RDLAT];
    logic          perr_q [RDLAT];
    logic          prd_q  [RDLAT];
    logic [CW-1:0] pcmd_q [RDLAT];
    logic [AW-1:0] pdst_q [RDLAT];
    logic [AW-1:0] psrc_q [RDLAT];

    logic [CW-1:0] qcmd_q  [DEPTH];
    logic [AW-1:0] qdst_q  [DEPTH];
    logic [AW-1:0] qsrc_q  [DEPTH];
    logic [DW-1:0] qdata_q [DEPTH];

    assign opc_s       = bus.udev_req_cmd[4:0];
    assign size_s      = bus.udev_req_cmd[7:5];
    assign len_s       = bus.udev_req_cmd[15:8];
    assign is_read_s   = (opc_s == UMI_REQ_READ);
    assign is_write_s  = (opc_s == UMI_REQ_WRITE);
    assign is_posted_s = (opc_s == UMI_REQ_POSTED);
    assign is_atomic_s = (opc_s == UMI_REQ_ATOMIC);
    assign is_rg_s     = is_read_s | is_write_s | is_atomic_s;
    assign is_unsup_s  = ~is_rg_s & ~is_posted_s;

    // An atomic carries its atype in the len field, so it always counts as one beat
    assign bytes_s   = (17'(is_atomic_s ? 8'h00 : len_s) + 17'd1) << size_s;
    assign illegal_s = (ERRCHK != 0) && (bytes_s > MAX_BYTES);

    assign ready_s  = rdy_en_q & bus.loc_ready & ((credit_q < DEPTH_C) | ~is_rg_s);
    assign accept_s = bus.udev_req_valid & ready_s;

    assign bus.udev_req_ready = ready_s;
    assign bus.loc_read   = accept_s & is_read_s & ~illegal_s;
    assign bus.loc_write  = accept_s & (is_write_s | is_posted_s) & ~illegal_s;
    assign bus.loc_atomic = accept_s & is_atomic_s & ~illegal_s;
    assign bus.loc_addr   = bus.udev_req_dstaddr;
    assign bus.loc_opcode = {3'b000, opc_s};
    assign bus.loc_size   = size_s;
    assign bus.loc_len    = len_s;
    assign bus.loc_atype  = len_s;
    assign bus.loc_wrdata = bus.udev_req_data;
    assign bus.err_drop   = err_drop_q;

    // Response header: request command with response opcode and error field patched
    always_comb begin
        resp_cmd_s      = bus.udev_req_cmd;
        resp_cmd_s[4:0] = is_write_s ? UMI_RESP_WRITE : UMI_RESP_READ;
        if (illegal_s) begin
            resp_cmd_s[26:25] = 2'b10;
        end else begin
            resp_cmd_s[26:25] = bus.udev_req_cmd[26:25];
        end
    end

    // Fixed-latency shift pipeline; the last stage lines up with loc_rddata
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RDLAT; i++) begin
                pv_q[i]   <= 1'b0;
                perr_q[i] <= 1'b0;
                prd_q[i]  <= 1'b0;
                pcmd_q[i] <= '0;
                pdst_q[i] <= '0;
                psrc_q[i] <= '0;
            end
        end else begin
            pv_q[0]   <= accept_s & is_rg_s;
            perr_q[0] <= illegal_s;
            prd_q[0]  <= is_read_s | is_atomic_s;
            pcmd_q[0] <= resp_cmd_s;
            pdst_q[0] <= bus.udev_req_srcaddr;
            psrc_q[0] <= bus.udev_req_dstaddr;
            for (int i = 1; i < RDLAT; i++) begin
                pv_q[i]   <= pv_q[i-1];
                perr_q[i] <= perr_q[i-1];
                prd_q[i]  <= prd_q[i-1];
                pcmd_q[i] <= pcmd_q[i-1];
                pdst_q[i] <= pdst_q[i-1];
                psrc_q[i] <= psrc_q[i-1];
            end
        end
    end

    assign push_s      = pv_q[RDLAT-1];
    assign push_data_s = (perr_q[RDLAT-1] | ~prd_q[RDLAT-1]) ? '0 : bus.loc_rddata;
    assign pop_s       = (count_q != '0) & bus.udev_resp_ready;

    // Queue/credit next state; credits bound occupancy so a push never finds it full
    always_comb begin
        credit_d = credit_q + CRW'(accept_s & is_rg_s) - CRW'(pop_s);
        count_d  = count_q + CRW'(push_s) - CRW'(pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state: credits, queue pointers, drop pulse and post-reset ready enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en_q   <= 1'b0;
            err_drop_q <= 1'b0;
            credit_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rdy_en_q   <= 1'b1;
            err_drop_q <= accept_s & ((is_posted_s & illegal_s) | is_unsup_s);
            credit_q   <= credit_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage; unwritten entries are never visible because outputs are masked when empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            qcmd_q[wr_ptr_q]  <= pcmd_q[RDLAT-1];
            qdst_q[wr_ptr_q]  <= pdst_q[RDLAT-1];
            qsrc_q[wr_ptr_q]  <= psrc_q[RDLAT-1];
            qdata_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign bus.udev_resp_valid   = (count_q != '0);
    assign bus.udev_resp_cmd     = bus.udev_resp_valid ? qcmd_q[rd_ptr_q]  : '0;
    assign bus.udev_resp_dstaddr = bus.udev_resp_valid ? qdst_q[rd_ptr_q]  : '0;
    assign bus.udev_resp_srcaddr = bus.udev_resp_valid ? qsrc_q[rd_ptr_q]  : '0;
    assign bus.udev_resp_data    = bus.udev_resp_valid ? qdata_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_umi_endpoint_pipe.sv
// Directed bench for umi_endpoint_pipe: instance A uses RDLAT=1, instance B uses RDLAT=3.
module tb_umi_endpoint_pipe;
    localparam logic [4:0] REQ_RD = 5'h01, REQ_WR = 5'h03, REQ_PW = 5'h05, REQ_AT = 5'h09;
    localparam logic [4:0] RSP_RD = 5'h02, RSP_WR = 5'h04;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   failures = 0;
    logic [255:0] a_rd = '0;

    always #5 clk = ~clk;

    umi_endpoint_pipe_if #(.CW(32), .AW(64), .DW(256)) a_if ();
    umi_endpoint_pipe_if #(.CW(32), .AW(64), .DW(256)) b_if ();

    umi_endpoint_pipe #(.CW(32), .AW(64), .DW(256), .RDLAT(1), .DEPTH(4), .ERRCHK(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(a_if));
    umi_endpoint_pipe #(.CW(32), .AW(64), .DW(256), .RDLAT(3), .DEPTH(4), .ERRCHK(1))
        dut_b (.clk(clk), .reset(rst_b), .bus(b_if));

    function automatic logic [31:0] mkcmd(input logic [4:0] opc, input logic [2:0] sz, input logic [7:0] ln);
        return {16'h0000, ln, sz, opc};
    endfunction

    // Local memory behaviour: read data = low address word + 0x1000
    function automatic logic [255:0] rdval(input logic [63:0] ad);
        return {224'h0, ad[31:0] + 32'h0000_1000};
    endfunction

    // Instance A local memory answers one cycle after a read/atomic strobe
    always @(posedge clk) begin
        if (a_if.loc_read | a_if.loc_atomic) a_rd <= rdval(a_if.loc_addr);
    end
    assign a_if.loc_rddata = a_rd;
    assign b_if.loc_rddata = '0;

    task automatic drv_a(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s);
        a_if.udev_req_valid = 1'b1;  a_if.udev_req_cmd = c;
        a_if.udev_req_dstaddr = d;   a_if.udev_req_srcaddr = s;
        a_if.udev_req_data = {192'h0, s};
    endtask

    task automatic drv_b(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s);
        b_if.udev_req_valid = 1'b1;  b_if.udev_req_cmd = c;
        b_if.udev_req_dstaddr = d;   b_if.udev_req_srcaddr = s;
        b_if.udev_req_data = {192'h0, s};
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        drv_a(mkcmd(REQ_RD, 3'd3, 8'd0), 64'h0, 64'h0);
        drv_b(mkcmd(REQ_WR, 3'd3, 8'd0), 64'h0, 64'h0);
        a_if.loc_ready = 1'b1; a_if.udev_resp_ready = 1'b1;
        b_if.loc_ready = 1'b1; b_if.udev_resp_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({a_if.udev_req_ready, a_if.udev_resp_valid, a_if.loc_read, a_if.err_drop,
             b_if.udev_req_ready, b_if.loc_write} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_outputs got a_rdy=%b a_rv=%b a_rd=%b a_ed=%b b_rdy=%b b_wr=%b exp all 0",
                     a_if.udev_req_ready, a_if.udev_resp_valid, a_if.loc_read, a_if.err_drop,
                     b_if.udev_req_ready, b_if.loc_write);
        end
        checks++;
        if ({a_if.udev_resp_cmd, a_if.udev_resp_data} !== 288'h0) begin
            failures++;
            $display("FAIL reset_resp_fields got cmd=%h exp 0", a_if.udev_resp_cmd);
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        a_if.udev_req_valid = 1'b0; b_if.udev_req_valid = 1'b0;
        #1;
        checks++;
        if (a_if.udev_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_first_edge got %b exp 0", a_if.udev_req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (a_if.udev_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got %b exp 1", a_if.udev_req_ready);
        end
    endtask

    task automatic test_back_to_back();
        a_if.udev_resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) drv_a(mkcmd(REQ_RD, 3'd3, 8'd0), 64'(8 * i), 64'h100 + 64'(i));
            else a_if.udev_req_valid = 1'b0;
            #1;
            if (i < 4) begin
                checks++;
                if ({a_if.udev_req_ready, a_if.loc_read, a_if.loc_addr} !== {2'b11, 64'(8 * i)}) begin
                    failures++;
                    $display("FAIL b2b_issue i=%0d got rdy=%b rd=%b addr=%h exp 1 1 %h", i,
                             a_if.udev_req_ready, a_if.loc_read, a_if.loc_addr, 64'(8 * i));
                end
            end
            checks++;
            if (i >= 2 && i < 6) begin
                if ({a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr,
                     a_if.udev_resp_srcaddr, a_if.udev_resp_data} !==
                    {1'b1, mkcmd(RSP_RD, 3'd3, 8'd0), 64'h100 + 64'(i - 2), 64'(8 * (i - 2)),
                     rdval(64'(8 * (i - 2)))}) begin
                    failures++;
                    $display("FAIL b2b_resp i=%0d got v=%b cmd=%h dst=%h src=%h data=%h", i,
                             a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr,
                             a_if.udev_resp_srcaddr, a_if.udev_resp_data[31:0]);
                end
            end else if (a_if.udev_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle i=%0d got valid=%b exp 0", i, a_if.udev_resp_valid);
            end
        end
    endtask

    task automatic test_credit_stall();
        int exp_idx [8] = '{0, 1, 2, 3, -1, 4, 5, -1};
        logic exp_rdy [3] = '{1'b0, 1'b1, 1'b1};
        int widx;
        b_if.udev_resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            widx = (c < 4) ? c : 4;
            drv_b(mkcmd(REQ_WR, 3'd3, 8'd0), 64'h400 + 64'(8 * widx), 64'h500 + 64'(widx));
            #1;
            checks++;
            if ({b_if.udev_req_ready, b_if.loc_write} !== {2{c < 4}}) begin
                failures++;
                $display("FAIL stall_ready c=%0d got rdy=%b wr=%b exp %b", c,
                         b_if.udev_req_ready, b_if.loc_write, c < 4);
            end
        end
        checks++;
        if ({b_if.udev_resp_valid, b_if.udev_resp_dstaddr} !== {1'b1, 64'h500}) begin
            failures++;
            $display("FAIL stall_head got v=%b dst=%h exp 1 500", b_if.udev_resp_valid, b_if.udev_resp_dstaddr);
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            b_if.udev_resp_ready = 1'b1;
            if (j < 3) drv_b(mkcmd(REQ_WR, 3'd3, 8'd0), 64'h400 + 64'(8 * ((j < 2) ? 4 : 5)),
                             64'h500 + 64'((j < 2) ? 4 : 5));
            else b_if.udev_req_valid = 1'b0;
            #1;
            if (j < 3) begin
                checks++;
                if (b_if.udev_req_ready !== exp_rdy[j]) begin
                    failures++;
                    $display("FAIL drain_ready j=%0d got %b exp %b", j, b_if.udev_req_ready, exp_rdy[j]);
                end
            end
            checks++;
            if (exp_idx[j] >= 0) begin
                if ({b_if.udev_resp_valid, b_if.udev_resp_cmd, b_if.udev_resp_dstaddr,
                     b_if.udev_resp_srcaddr, b_if.udev_resp_data} !==
                    {1'b1, mkcmd(RSP_WR, 3'd3, 8'd0), 64'h500 + 64'(exp_idx[j]),
                     64'h400 + 64'(8 * exp_idx[j]), 256'h0}) begin
                    failures++;
                    $display("FAIL drain_resp j=%0d got v=%b cmd=%h dst=%h src=%h exp idx %0d", j,
                             b_if.udev_resp_valid, b_if.udev_resp_cmd, b_if.udev_resp_dstaddr,
                             b_if.udev_resp_srcaddr, exp_idx[j]);
                end
            end else if (b_if.udev_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL drain_gap j=%0d got valid=%b exp 0", j, b_if.udev_resp_valid);
            end
        end
    endtask

    task automatic test_posted_at_full();
        a_if.udev_resp_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c >= 5 && c < 8) drv_a(mkcmd(REQ_PW, 3'd3, 8'd0), 64'h700 + 64'(8 * c), 64'h0);
            else drv_a(mkcmd(REQ_RD, 3'd3, 8'd0), 64'h200 + 64'(8 * c), 64'h600 + 64'(c));
            #1;
            checks++;
            if (c < 4) begin
                if ({a_if.udev_req_ready, a_if.loc_read} !== 2'b11) begin
                    failures++;
                    $display("FAIL full_fill c=%0d got rdy=%b rd=%b exp 1 1", c, a_if.udev_req_ready, a_if.loc_read);
                end
            end else if (c >= 5 && c < 8) begin
                if ({a_if.udev_req_ready, a_if.loc_write, a_if.err_drop} !== 3'b110) begin
                    failures++;
                    $display("FAIL posted_at_full c=%0d got rdy=%b wr=%b drop=%b exp 1 1 0", c,
                             a_if.udev_req_ready, a_if.loc_write, a_if.err_drop);
                end
            end else if ({a_if.udev_req_ready, a_if.loc_read} !== 2'b00) begin
                failures++;
                $display("FAIL read_blocked c=%0d got rdy=%b rd=%b exp 0 0", c, a_if.udev_req_ready, a_if.loc_read);
            end
        end
        @(negedge clk);
        a_if.udev_req_valid = 1'b0;
        #1;
        checks++;
        if ({a_if.udev_resp_valid, a_if.udev_resp_srcaddr} !== {1'b1, 64'h200}) begin
            failures++;
            $display("FAIL full_head got v=%b src=%h exp 1 200", a_if.udev_resp_valid, a_if.udev_resp_srcaddr);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            a_if.udev_resp_ready = 1'b1;
            #1;
            checks++;
            if (j < 4) begin
                if ({a_if.udev_resp_valid, a_if.udev_resp_srcaddr, a_if.udev_resp_data} !==
                    {1'b1, 64'h200 + 64'(8 * j), rdval(64'h200 + 64'(8 * j))}) begin
                    failures++;
                    $display("FAIL full_drain j=%0d got v=%b src=%h data=%h", j,
                             a_if.udev_resp_valid, a_if.udev_resp_srcaddr, a_if.udev_resp_data[31:0]);
                end
            end else if (a_if.udev_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL posted_no_resp got valid=%b exp 0", a_if.udev_resp_valid);
            end
        end
    endtask

    task automatic test_error_order();
        a_if.udev_resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) drv_a(mkcmd(REQ_RD, 3'd3, 8'd0), 64'h300, 64'h800);
            else if (c == 1) drv_a(mkcmd(REQ_RD, 3'd3, 8'd31), 64'h308, 64'h801);
            else if (c == 2) drv_a(mkcmd(REQ_RD, 3'd3, 8'd0), 64'h310, 64'h802);
            else a_if.udev_req_valid = 1'b0;
            #1;
            if (c == 1) begin
                checks++;
                if ({a_if.udev_req_ready, a_if.loc_read} !== 2'b10) begin
                    failures++;
                    $display("FAIL illegal_no_strobe got rdy=%b rd=%b exp 1 0", a_if.udev_req_ready, a_if.loc_read);
                end
            end
            checks++;
            if (c == 2 && {a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr, a_if.udev_resp_data,
                           a_if.err_drop} !== {1'b1, 32'h0000_0062, 64'h800, rdval(64'h300), 1'b0}) begin
                failures++;
                $display("FAIL err_before got v=%b cmd=%h dst=%h drop=%b", a_if.udev_resp_valid,
                         a_if.udev_resp_cmd, a_if.udev_resp_dstaddr, a_if.err_drop);
            end else if (c == 3 && {a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr,
                                    a_if.udev_resp_srcaddr, a_if.udev_resp_data} !==
                                   {1'b1, 32'h0400_1F62, 64'h801, 64'h308, 256'h0}) begin
                failures++;
                $display("FAIL err_resp got v=%b cmd=%h dst=%h data=%h exp 1 04001f62 801 0",
                         a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr, a_if.udev_resp_data[31:0]);
            end else if (c == 4 && {a_if.udev_resp_valid, a_if.udev_resp_dstaddr, a_if.udev_resp_data} !==
                                   {1'b1, 64'h802, rdval(64'h310)}) begin
                failures++;
                $display("FAIL err_after got v=%b dst=%h data=%h", a_if.udev_resp_valid,
                         a_if.udev_resp_dstaddr, a_if.udev_resp_data[31:0]);
            end else if ((c < 2 || c == 5) && a_if.udev_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL err_idle c=%0d got valid=%b exp 0", c, a_if.udev_resp_valid);
            end
        end
    endtask

    task automatic test_atomic_unsup();
        a_if.udev_resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) drv_a(mkcmd(REQ_AT, 3'd2, 8'h05), 64'hCEAD, 64'h900);
            else if (c == 3) drv_a(mkcmd(5'h0F, 3'd3, 8'd0), 64'h40, 64'h41);
            else if (c == 5) drv_a(mkcmd(REQ_PW, 3'd3, 8'd31), 64'h48, 64'h49);
            else a_if.udev_req_valid = 1'b0;
            #1;
            checks++;
            if (c == 0 && {a_if.loc_atomic, a_if.loc_read, a_if.loc_atype, a_if.loc_opcode} !==
                          {2'b10, 8'h05, 8'h09}) begin
                failures++;
                $display("FAIL atomic_issue got at=%b rd=%b atype=%h opc=%h exp 1 0 05 09",
                         a_if.loc_atomic, a_if.loc_read, a_if.loc_atype, a_if.loc_opcode);
            end else if (c == 2 && {a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_dstaddr,
                                    a_if.udev_resp_srcaddr, a_if.udev_resp_data} !==
                                   {1'b1, 32'h0000_0542, 64'h900, 64'hCEAD, 256'hDEAD}) begin
                failures++;
                $display("FAIL atomic_resp got v=%b cmd=%h data=%h exp 1 00000542 dead",
                         a_if.udev_resp_valid, a_if.udev_resp_cmd, a_if.udev_resp_data[31:0]);
            end else if ((c == 3 || c == 5) && {a_if.udev_req_ready, a_if.loc_read, a_if.loc_write,
                                                a_if.loc_atomic} !== 4'b1000) begin
                failures++;
                $display("FAIL drop_no_strobe c=%0d got rdy=%b rd=%b wr=%b at=%b exp 1 0 0 0", c,
                         a_if.udev_req_ready, a_if.loc_read, a_if.loc_write, a_if.loc_atomic);
            end else if (c != 0 && c != 2 && c != 3 && c != 5 &&
                         {a_if.err_drop, a_if.udev_resp_valid} !== {(c == 4 || c == 6), 1'b0}) begin
                failures++;
                $display("FAIL err_drop c=%0d got drop=%b valid=%b exp %b 0", c, a_if.err_drop,
                         a_if.udev_resp_valid, (c == 4 || c == 6));
            end
        end
    endtask

    task automatic test_reset_midflight();
        int cnt = 0;
        b_if.udev_resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) drv_b(mkcmd(REQ_WR, 3'd3, 8'd0), 64'hA00 + 64'(8 * c), 64'hA80 + 64'(c));
            else b_if.udev_req_valid = 1'b0;
        end
        @(negedge clk); #1;
        checks++;
        if (b_if.udev_resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL queued_before_reset got %b exp 1", b_if.udev_resp_valid);
        end
        rst_b = 1'b1;
        #1;
        checks++;
        if ({b_if.udev_resp_valid, b_if.udev_req_ready, b_if.udev_resp_cmd} !== 34'h0) begin
            failures++;
            $display("FAIL reset_immediate got v=%b rdy=%b cmd=%h exp 0 0 0", b_if.udev_resp_valid,
                     b_if.udev_req_ready, b_if.udev_resp_cmd);
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checks++;
        if (b_if.udev_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_midreset got %b exp 0", b_if.udev_req_ready);
        end
        @(negedge clk);
        b_if.udev_resp_ready = 1'b1;
        drv_b(mkcmd(REQ_WR, 3'd3, 8'd0), 64'hB00, 64'hB01);
        #1;
        checks++;
        if ({b_if.udev_req_ready, b_if.loc_write} !== 2'b11) begin
            failures++;
            $display("FAIL post_reset_accept got rdy=%b wr=%b exp 1 1", b_if.udev_req_ready, b_if.loc_write);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            b_if.udev_req_valid = 1'b0;
            #1;
            if (b_if.udev_resp_valid === 1'b1) begin
                cnt++;
                checks++;
                if (b_if.udev_resp_srcaddr !== 64'hB00) begin
                    failures++;
                    $display("FAIL post_reset_resp got src=%h exp b00", b_if.udev_resp_srcaddr);
                end
            end
        end
        checks++;
        if (cnt != 1) begin
            failures++;
            $display("FAIL post_reset_count got %0d exp 1", cnt);
        end
    endtask

    initial begin
        a_if.udev_req_valid = 1'b0; b_if.udev_req_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_credit_stall();
        test_posted_at_full();
        test_error_order();
        test_atomic_unsup();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
